// File: rtl/mips_cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM states, failure codes and
// the per-state drive pattern for the CPU control and status outputs.
package mips_cpu_run_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StArm,
    StRun,
    StCheck,
    StDone
  } run_state_e;

  typedef enum logic [2:0] {
    FailNone      = 3'd0,
    FailTimeout   = 3'd1,
    FailNotActive = 3'd2,
    FailMismatch  = 3'd3,
    FailAbort     = 3'd4
  } fail_code_e;

  typedef struct packed {
    logic cpu_rst;
    logic cpu_clk_enable;
    logic busy;
    logic done;
  } run_drive_t;

  // Control/status pattern that belongs to each state.
  function automatic run_drive_t state_drive(input run_state_e st);
    run_drive_t d;
    d = '{cpu_rst: 1'b1, cpu_clk_enable: 1'b0, busy: 1'b0, done: 1'b0};
    unique case (st)
      StIdle:  d = '{cpu_rst: 1'b1, cpu_clk_enable: 1'b0, busy: 1'b0, done: 1'b0};
      StReset: d = '{cpu_rst: 1'b1, cpu_clk_enable: 1'b0, busy: 1'b1, done: 1'b0};
      StArm:   d = '{cpu_rst: 1'b0, cpu_clk_enable: 1'b1, busy: 1'b1, done: 1'b0};
      StRun:   d = '{cpu_rst: 1'b0, cpu_clk_enable: 1'b1, busy: 1'b1, done: 1'b0};
      // CPU frozen while results are compared
      StCheck: d = '{cpu_rst: 1'b0, cpu_clk_enable: 1'b0, busy: 1'b0, done: 1'b0};
      // CPU held out of reset with its clock stopped so its state stays readable
      StDone:  d = '{cpu_rst: 1'b0, cpu_clk_enable: 1'b0, busy: 1'b0, done: 1'b1};
      default: d = '{cpu_rst: 1'b1, cpu_clk_enable: 1'b0, busy: 1'b0, done: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_cpu_result_cmp.sv
// Per-channel result comparator: flags every enabled channel whose observed
// word differs from its reference word.
module mips_cpu_result_cmp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CHECKS = 1
) (
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] observed,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] expected,
  input  logic [NUM_CHECKS-1:0]            check_mask,
  output logic [NUM_CHECKS-1:0]            mismatch
);

  // Compare each packed channel, gated by its enable bit.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      mismatch[i] = check_mask[i] &
                    (observed[i*DATA_WIDTH +: DATA_WIDTH] != expected[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

endmodule

// File: rtl/mips_cpu_run_ctrl.sv
// Run controller for a CPU under test: resets the CPU, lets it run until it
// drops cpu_active or a cycle budget expires, then compares its result words
// against reference values and reports pass/fail with a failure code.
module mips_cpu_run_ctrl
  import mips_cpu_run_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_CHECKS     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned RESET_CYCLES   = 1,
  localparam int unsigned CntW          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            cpu_rst,
  output logic                            cpu_clk_enable,
  input  logic                            cpu_active,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] observed,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] expected,
  input  logic [NUM_CHECKS-1:0]            check_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [2:0]                      fail_code,
  output logic [NUM_CHECKS-1:0]           mismatch_mask,
  output logic [CntW-1:0]                 cycle_count
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

  run_state_e              state_q, state_d;
  logic [RstW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  fail_code_e              fail_q, fail_d;
  logic [NUM_CHECKS-1:0]   mask_q, mask_d;
  logic [NUM_CHECKS-1:0]   cmp_mismatch;
  run_drive_t              drive_d;
  logic                    in_run_window;

  mips_cpu_result_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_cmp (
    .observed   (observed),
    .expected   (expected),
    .check_mask (check_mask),
    .mismatch   (cmp_mismatch)
  );

  // States in which abort terminates the run.
  assign in_run_window = (state_q == StReset) || (state_q == StArm) ||
                         (state_q == StRun)   || (state_q == StCheck);

  // Next-state and result bookkeeping; abort overrides every other transition.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    mask_d    = mask_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StReset;
          rst_cnt_d = '0;
          cnt_d     = '0;
          fail_d    = FailNone;
          mask_d    = '0;
        end
      end
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StArm;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StArm: begin
        if (cpu_active) begin
          state_d = StRun;
        end else begin
          state_d = StDone;
          fail_d  = FailNotActive;
        end
      end
      StRun: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // Completion is tested first so it wins over a coincident timeout.
        if (!cpu_active) begin
          state_d = StCheck;
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          fail_d  = FailTimeout;
        end
      end
      StCheck: begin
        mask_d  = cmp_mismatch;
        fail_d  = (|cmp_mismatch) ? FailMismatch : FailNone;
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && in_run_window) begin
      state_d = StDone;
      fail_d  = FailAbort;
      mask_d  = mask_q;
    end

    drive_d = state_drive(state_d);
  end

  // State, result registers and registered control/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      rst_cnt_q      <= '0;
      cnt_q          <= '0;
      fail_q         <= FailNone;
      mask_q         <= '0;
      cpu_rst        <= 1'b1;
      cpu_clk_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      cnt_q          <= cnt_d;
      fail_q         <= fail_d;
      mask_q         <= mask_d;
      cpu_rst        <= drive_d.cpu_rst;
      cpu_clk_enable <= drive_d.cpu_clk_enable;
      busy           <= drive_d.busy;
      done           <= drive_d.done;
      pass           <= (state_d == StDone) && (fail_d == FailNone);
    end
  end

  assign fail_code     = fail_q;
  assign mismatch_mask = mask_q;
  assign cycle_count   = cnt_q;

endmodule

// File: doc/mips_cpu_run_ctrl.md
MIPS_CPU_RUN_CTRL -- requirements
Module: mips_cpu_run_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one result word.
REQ-002 Parameter NUM_CHECKS, default 1: number of result channels compared at end of run.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: maximum RUN-state cycles before timeout; legal range >= 2.
REQ-004 Parameter RESET_CYCLES, default 1: number of cycles cpu_rst is held in the RESET state; legal range >= 1.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 start  in  1  run request; sampled only in IDLE and DONE.
REQ-008 abort  in  1  terminates any busy run.
REQ-009 cpu_rst  out  1  reset drive to the CPU under control.
REQ-010 cpu_clk_enable  out  1  clock enable drive to the CPU.
REQ-011 cpu_active  in  1  CPU active flag.
REQ-012 observed  in  NUM_CHECKS*DATA_WIDTH  CPU result words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 expected  in  NUM_CHECKS*DATA_WIDTH  reference words, same packing as observed.
REQ-014 check_mask  in  NUM_CHECKS  a 1 enables comparison of that channel.
REQ-015 busy  out  1  high in RESET, ARM and RUN.
REQ-016 done  out  1  high in DONE.
REQ-017 pass  out  1  high in DONE when fail_code = NONE.
REQ-018 fail_code  out  3  0 NONE, 1 TIMEOUT, 2 NOT_ACTIVE, 3 MISMATCH, 4 ABORT.
REQ-019 mismatch_mask  out  NUM_CHECKS  registered per-channel mismatch flags from the last CHECK.
REQ-020 cycle_count  out  $clog2(TIMEOUT_CYCLES+1)  number of RUN cycles in the current or last run.

Function
REQ-021 The FSM SHALL have the states IDLE, RESET, ARM, RUN, CHECK and DONE.
REQ-022 IDLE or DONE with start=1 -> RESET; on that entry, cycle_count, fail_code and mismatch_mask SHALL be cleared.
REQ-023 RESET: cpu_rst=1 and cpu_clk_enable=0 for exactly RESET_CYCLES cycles, then -> ARM.
REQ-024 ARM: cpu_rst=0 and cpu_clk_enable=1 for 1 cycle; cpu_active sampled at the end of ARM: 1 -> RUN; 0 -> DONE with NOT_ACTIVE.
REQ-025 RUN: cpu_clk_enable=1; cycle_count increments every cycle and saturates at TIMEOUT_CYCLES.
REQ-026 RUN with cpu_active=0 -> CHECK.
REQ-027 RUN with cpu_active=1 and cycle_count = TIMEOUT_CYCLES-1 -> DONE with TIMEOUT.
REQ-028 If cpu_active falls in the same cycle as the timeout condition, completion SHALL win and the FSM goes to CHECK.
REQ-029 CHECK lasts 1 cycle with cpu_clk_enable=0. mismatch_mask[i] = check_mask[i] & (observed_i != expected_i). Any mismatch bit set -> MISMATCH, otherwise NONE. Then -> DONE.
REQ-030 DONE: cpu_clk_enable=0 and cpu_rst=0, so CPU state stays readable; all result outputs are held until the next start.
REQ-031 IDLE: cpu_rst=1 and cpu_clk_enable=0.
REQ-032 abort=1 in RESET, ARM, RUN or CHECK -> DONE with ABORT next cycle; abort has priority over every other transition.
REQ-033 start SHALL be ignored while busy or in CHECK.
REQ-034 check_mask all zero SHALL give pass on completion.

Reset
REQ-035 While rst=1: state=IDLE, cpu_rst=1, cpu_clk_enable=0, busy=0, done=0, pass=0, fail_code=0, mismatch_mask=0, cycle_count=0.
REQ-036 rst asserted mid-run SHALL abandon the run with no DONE indication.

Structure
REQ-037 The state enum and fail-code enum SHALL live in the shared package mips_cpu_run_pkg.
REQ-038 The per-channel comparator SHALL be the sub-module mips_cpu_result_cmp, parametrised by DATA_WIDTH and NUM_CHECKS.

Verification
REQ-039 Test 1, normal completion: NUM_CHECKS=1, start pulse, cpu_active=1 for 20 cycles then 0, observed=expected=32'h0000_0005 -> done=1, pass=1, cycle_count=20.
REQ-040 Test 2, timeout: TIMEOUT_CYCLES=50, cpu_active held at 1 -> done with fail_code=1 after 50 RUN cycles, with cpu_clk_enable=0 in DONE.
REQ-041 Test 3, not active: cpu_active=0 throughout ARM -> fail_code=2, RUN never entered, cycle_count=0.
REQ-042 Test 4, channel mismatch: NUM_CHECKS=3, check_mask=3'b101, channel 1 differs, channel 2 differs -> mismatch_mask=3'b100, fail_code=3.
REQ-043 Test 5, boundary and abort:
- cpu_active falls on cycle 49 with TIMEOUT_CYCLES=50 -> CHECK path taken, not TIMEOUT.
- abort in RUN -> fail_code=4 next cycle.
REQ-044 Test 6, reset and restart:
- rst pulsed mid-RUN -> all outputs equal their REQ-035 values.
- Restart from DONE clears cycle_count and fail_code.
